// File: rtl/lru_tracker.sv
// Per-set true-LRU tracker: valid bit and age rank per way, with touch/allocate/invalidate and a table flush.
// Latency: response registered one cycle after the accepting edge; one request per cycle.
// Backpressure: req_ready_o drops while flushing or while flush_i is raised in IDLE.
module lru_tracker #(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [SET_W-1:0] req_set_i,
    input  logic [WAY_W-1:0] req_way_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    output logic [WAY_W-1:0] rsp_way_o,
    output logic             rsp_evict_o,
    output logic             busy_o
);
    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [WAY_W-1:0] AGE_LRU  = WAY_W'(NUM_WAYS - 1);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    function automatic logic [NUM_WAYS-1:0][WAY_W-1:0] init_ages();
        logic [NUM_WAYS-1:0][WAY_W-1:0] a;
        for (int w = 0; w < NUM_WAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction

    localparam logic [NUM_WAYS-1:0][WAY_W-1:0] INIT_AGE = init_ages();

    logic [NUM_WAYS-1:0]             valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0][WAY_W-1:0]  age_q   [NUM_SETS];

    logic [0:0]       state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q;
    logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
    logic             rsp_evict_q, rsp_evict_d;

    logic                            fire;
    logic [NUM_WAYS-1:0]             rd_valid, valid_d;
    logic [NUM_WAYS-1:0][WAY_W-1:0]  rd_age, age_d;
    logic [WAY_W-1:0]                victim, tgt_way, tgt_age;
    logic                            found;

    assign req_ready_o = (state_q == ST_IDLE) && !flush_i;
    assign fire        = req_valid_i && req_ready_o;
    assign busy_o      = (state_q == ST_FLUSH);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_way_o   = rsp_way_q;
    assign rsp_evict_o = rsp_evict_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (flush_i) begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) state_d = ST_IDLE;
        end
    end

    // Victim: lowest invalid way first, otherwise the way holding the LRU rank.
    always_comb begin
        rd_valid = valid_q[req_set_i];
        rd_age   = age_q[req_set_i];
        victim   = '0;
        found    = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!rd_valid[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (rd_age[w] == AGE_LRU) victim = WAY_W'(w);
            end
        end

        tgt_way = (req_op_i == OP_ALLOC) ? victim : req_way_i;
        tgt_age = rd_age[tgt_way];
        valid_d = rd_valid;
        age_d   = rd_age;

        case (req_op_i)
            OP_TOUCH, OP_ALLOC: begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (rd_age[w] < tgt_age) age_d[w] = rd_age[w] + 1'b1;
                end
                age_d[tgt_way]   = '0;
                valid_d[tgt_way] = 1'b1;
            end
            OP_INVAL: begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (rd_age[w] > tgt_age) age_d[w] = rd_age[w] - 1'b1;
                end
                age_d[tgt_way]   = AGE_LRU;
                valid_d[tgt_way] = 1'b0;
            end
            default: ;
        endcase

        rsp_way_d   = tgt_way;
        rsp_evict_d = (req_op_i == OP_ALLOC) && rd_valid[victim];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= INIT_AGE;
            end
        end else if (state_q == ST_FLUSH) begin
            valid_q[cnt_q] <= '0;
            age_q[cnt_q]   <= INIT_AGE;
        end else if (fire && (req_op_i != OP_NOP)) begin
            valid_q[req_set_i] <= valid_d;
            age_q[req_set_i]   <= age_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_evict_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= fire;
            if (fire) begin
                rsp_way_q   <= rsp_way_d;
                rsp_evict_q <= rsp_evict_d;
            end
        end
    end
endmodule

// File: doc/lru_tracker.md
# lru_tracker

Parametrised per-set true-LRU replacement tracker for the set-associative cache. It holds a valid bit and an age rank for every way of every set. It accepts touch/allocate/invalidate requests over a valid/ready handshake and returns the selected way one cycle later. It also provides a multi-cycle flush sequencer that clears the whole table.

## Interface
Parameters:
- NUM_SETS, 64, number of sets; power of two, ≥2; SET_W = $clog2(NUM_SETS)
- NUM_WAYS, 4, ways per set; power of two, ≥2; WAY_W = $clog2(NUM_WAYS)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  2  00 touch, 01 allocate, 10 invalidate, 11 no-op
- req_set_i  in  SET_W  target set
- req_way_i  in  WAY_W  target way (touch/invalidate; ignored for allocate)
- flush_i  in  1  start table flush (level, sampled in IDLE)
- rsp_valid_o  out  1  one-cycle pulse per accepted request
- rsp_way_o  out  WAY_W  victim way (allocate), else echoed req_way_i
- rsp_evict_o  out  1  allocate chose a way that was valid
- busy_o  out  1  flush in progress

## Operation
- Per set: valid[w] and age[w] (WAY_W bits). The ages of a set always form a permutation of 0..NUM_WAYS-1. Age 0 is MRU; NUM_WAYS-1 is LRU.
- Init contents (reset and flush): valid=0 and age[w]=w for every set, so way NUM_WAYS-1 is LRU.
- Touch(w): every way with age < age[w] increments; age[w]←0; valid[w]←1.
- Allocate: victim = lowest-index way with valid=0; if all ways are valid, victim = the way with age NUM_WAYS-1. The victim is then promoted exactly as in touch. rsp_evict_o = prior valid[victim].
- Invalidate(w): every way with age > age[w] decrements; age[w]←NUM_WAYS-1; valid[w]←0.
- No-op (11): state unchanged. The request still produces a response with rsp_way_o=req_way_i and rsp_evict_o=0.
- rsp_evict_o=0 for every op except allocate.
- FSM states:
  - IDLE: req_ready_o = ~flush_i. If flush_i=1, go to FLUSH with flush counter=0.
  - FLUSH: write init contents to set[counter], one set per cycle. After set NUM_SETS-1 is written, return to IDLE. req_ready_o=0; busy_o=1; flush_i is ignored.
- Simultaneous flush_i and req_valid_i in IDLE: the request is not accepted and the flush wins. The requester must hold the request until ready.
- Table updates from back-to-back requests to the same set are seen by the next request. The table is read combinationally and written at the accepting edge.

## Timing
- Reset values: rsp_valid_o=0, rsp_way_o=0, rsp_evict_o=0, busy_o=0, state IDLE, so req_ready_o=1 if flush_i=0. The whole table is set to init contents in the reset cycle.
- Latency: a request accepted at edge N produces registered rsp_* valid for exactly the cycle after edge N. Throughput is one request per cycle.
- rsp_way_o and rsp_evict_o hold their last values when rsp_valid_o=0.
- Flush entered at edge N: busy_o=1 from edge N. The edge-N+1…N+NUM_SETS write cycles clear the sets. IDLE (busy_o=0, ready=1) is reached after edge N+NUM_SETS. Total NUM_SETS cycles busy.
- A response for a request accepted in the same edge that enters FLUSH cannot occur, because ready is gated by flush_i.
- rst_ni low during FLUSH: the next edge forces IDLE with the full table initialised. The flush counter is discarded.

## Test plan
- Reset, then 4 allocates to set 5 (NUM_WAYS=4) -> rsp_way_o 0,1,2,3 with rsp_evict_o=0 each. A 5th allocate -> way 0, rsp_evict_o=1.
- Set 5 full. Touch way 0, then allocate -> victim way 1 with evict=1. Then touch 2, touch 1, allocate -> victim 3.
- Set 5 full. Invalidate way 2, then allocate -> way 2 with evict=0. Ages in set 5 remain a permutation after every op; check by scoreboard.
- Back-to-back allocates to the same set on consecutive cycles -> distinct victims. rsp_valid_o is high for 2 consecutive cycles.
- flush_i with req_valid_i in the same cycle -> ready=0 and busy_o=1 for 64 cycles. An allocate on any set afterwards -> way 0 with evict=0. The held request is accepted in the first IDLE cycle.
- Reset pulsed at flush cycle 10 -> IDLE next cycle, busy_o=0. All sets read as init; the first allocate to set 63 -> way 0 with evict=0.
